// File: rtl/fetch_queue_if.sv
`timescale 1ns/1ps
// Fetch queue bundle: redirect input, imem request/response channel and decode handshake.
interface fetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          imem_req_valid;
   logic [31:0]   imem_req_addr;
   logic          imem_req_ready;
   logic          imem_resp_valid;
   logic [31:0]   imem_resp_data;
   logic          dec_valid;
   logic [31:0]   dec_inst;
   logic [31:0]   dec_pc;
   logic          dec_ready;
   logic [CW-1:0] queue_count;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
      output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc, queue_count
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
      input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc, queue_count
   );
endinterface

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// Fetch front end: sequential imem requests under a credit limit, in-order capture of
// responses into a PC-tagged FIFO for decode, and redirect flush with stale-response drop.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0100_0000,
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2
) (
   input  logic          clock,
   input  logic          reset,
   fetch_queue_if.master fq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [OW-1:0] OUT_ZERO = {OW{1'b0}};
   localparam logic [OW-1:0] OUT_ONE  = OW'(1'b1);

   logic [31:0]   fetch_pc_r;
   logic [31:0]   resp_pc_r;
   logic [OW-1:0] outstanding_r;
   logic [OW-1:0] drop_cnt_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [31:0]   inst_mem_r [DEPTH];
   logic [31:0]   pc_mem_r   [DEPTH];

   logic [31:0]   credit_sum_s;
   logic [31:0]   target_pc_s;
   logic          not_empty_s;
   logic          req_valid_s;
   logic          req_fire_s;
   logic          resp_take_s;
   logic          drop_s;
   logic          push_s;
   logic          dec_valid_s;
   logic          pop_s;
   logic [OW-1:0] outstanding_next_s;

   // Issue credit keeps count + outstanding <= DEPTH, so a push never finds the FIFO full
   always_comb begin
      credit_sum_s = 32'(count_r) + 32'(outstanding_r);
      target_pc_s  = fq.redirect_pc & 32'hFFFF_FFFC;
      not_empty_s  = (count_r != CNT_ZERO);
      req_valid_s  = ~reset & ~fq.redirect_valid
                     & (32'(outstanding_r) < 32'(MAX_OUT))
                     & (credit_sum_s < 32'(DEPTH));
      req_fire_s   = req_valid_s & fq.imem_req_ready;
      resp_take_s  = fq.imem_resp_valid & (outstanding_r != OUT_ZERO);
      drop_s       = resp_take_s & (drop_cnt_r != OUT_ZERO);
      push_s       = resp_take_s & ~drop_s & ~fq.redirect_valid;
      dec_valid_s  = ~reset & not_empty_s & ~fq.redirect_valid;
      pop_s        = dec_valid_s & fq.dec_ready;
      if (req_fire_s && !resp_take_s) begin
         outstanding_next_s = outstanding_r + OUT_ONE;
      end else if (!req_fire_s && resp_take_s) begin
         outstanding_next_s = outstanding_r - OUT_ONE;
      end else begin
         outstanding_next_s = outstanding_r;
      end
   end

   assign fq.imem_req_valid = req_valid_s;
   assign fq.imem_req_addr  = reset ? 32'h0000_0000 : fetch_pc_r;
   assign fq.dec_valid      = dec_valid_s;
   assign fq.dec_inst       = not_empty_s ? inst_mem_r[rd_ptr_r] : 32'h0000_0000;
   assign fq.dec_pc         = not_empty_s ? pc_mem_r[rd_ptr_r] : 32'h0000_0000;
   assign fq.queue_count    = count_r;

   // PCs, request credit, drop tracking and FIFO occupancy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         outstanding_r <= OUT_ZERO;
         drop_cnt_r    <= OUT_ZERO;
         rd_ptr_r      <= PTR_ZERO;
         wr_ptr_r      <= PTR_ZERO;
         count_r       <= CNT_ZERO;
      end else begin
         outstanding_r <= outstanding_next_s;
         if (fq.redirect_valid) begin
            // every request still in flight after this cycle belongs to the old path
            fetch_pc_r <= target_pc_s;
            resp_pc_r  <= target_pc_s;
            drop_cnt_r <= outstanding_next_s;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
         end else begin
            if (req_fire_s) begin
               fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (drop_s) begin
               drop_cnt_r <= drop_cnt_r - OUT_ONE;
            end
            if (push_s) begin
               resp_pc_r <= resp_pc_r + 32'd4;
               wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
               count_r <= count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
               count_r <= count_r - CNT_ONE;
            end
         end
      end
   end

   // FIFO storage; occupancy gating makes a reset of the array unnecessary
   always_ff @(posedge clock) begin
      if (push_s) begin
         inst_mem_r[wr_ptr_r] <= fq.imem_resp_data;
         pc_mem_r[wr_ptr_r]   <= resp_pc_r;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// Bench for fetch_queue: in-order imem model with configurable latency feeding a
// scoreboard of expected {pc, inst} pairs that is flushed on every redirect.
module tb_fetch_queue;
   localparam logic [31:0] RESET_PC = 32'h0100_0000;
   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;

   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
   typedef struct { logic [31:0] addr; int due; } req_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fetch_queue_if #(.DEPTH(DEPTH)) fif ();

   fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clock (clock),
      .reset (reset),
      .fq    (fif.master)
   );

   always #5 clock = ~clock;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          n_deliv = 0;
   int          first_dec_cyc = -1;
   logic [31:0] first_dec_pc = 32'h0;
   logic [31:0] exp_req_addr = RESET_PC;
   logic        tb_redirect = 1'b0;
   logic [31:0] tb_redirect_pc = 32'h0;
   logic        tb_req_ready = 1'b1;
   logic        tb_dec_ready = 1'b1;
   logic        s_req_valid;
   logic [2:0]  s_count;
   exp_t        sb_q[$];
   req_t        pend_q[$];
   logic [31:0] mark_fires[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:24], ~a[15:8], a[23:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic drive_idle();
      fif.redirect_valid  = 1'b0;
      fif.redirect_pc     = 32'h0;
      fif.imem_req_ready  = 1'b1;
      fif.imem_resp_valid = 1'b0;
      fif.imem_resp_data  = 32'h0;
      fif.dec_ready       = 1'b1;
   endtask

   task automatic mark();
      first_dec_cyc = -1;
      first_dec_pc  = 32'h0;
      n_deliv       = 0;
      mark_fires.delete();
   endtask

   // One clock: drive inputs, sample at negedge, score handshakes, advance past posedge
   task automatic cycle();
      logic resp_v;
      exp_t e;
      resp_v = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
      fif.redirect_valid  = tb_redirect;
      fif.redirect_pc     = tb_redirect_pc;
      fif.imem_req_ready  = tb_req_ready;
      fif.dec_ready       = tb_dec_ready;
      fif.imem_resp_valid = resp_v;
      if (resp_v) fif.imem_resp_data = mem_word(pend_q[0].addr);
      else        fif.imem_resp_data = 32'h0;
      @(negedge clock);
      s_req_valid = fif.imem_req_valid;
      s_count     = fif.queue_count;
      n_tests++;
      if (fif.queue_count > 3'(DEPTH)) begin
         n_fail++;
         $display("FAIL overflow: queue_count=%0d, required <= %0d", fif.queue_count, DEPTH);
      end
      if (tb_redirect) begin
         n_tests++;
         if (fif.dec_valid !== 1'b0 || fif.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_quiet: dec_valid=%b req_valid=%b, required 0 0",
                     fif.dec_valid, fif.imem_req_valid);
         end
      end
      if (fif.dec_valid === 1'b1 && tb_dec_ready) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL dec_unexpected: pc=%08h delivered, required nothing", fif.dec_pc);
         end else begin
            e = sb_q.pop_front();
            if (fif.dec_pc !== e.pc || fif.dec_inst !== e.inst) begin
               n_fail++;
               $display("FAIL dec_entry: pc=%08h inst=%08h, required pc=%08h inst=%08h",
                        fif.dec_pc, fif.dec_inst, e.pc, e.inst);
            end
         end
         if (first_dec_cyc < 0) begin
            first_dec_cyc = cyc;
            first_dec_pc  = fif.dec_pc;
         end
         n_deliv++;
      end
      if (fif.imem_req_valid === 1'b1 && tb_req_ready) begin
         n_tests++;
         if (fif.imem_req_addr !== exp_req_addr) begin
            n_fail++;
            $display("FAIL req_addr: addr=%08h, required %08h", fif.imem_req_addr, exp_req_addr);
         end
         sb_q.push_back('{pc: exp_req_addr, inst: mem_word(exp_req_addr)});
         pend_q.push_back('{addr: fif.imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
         mark_fires.push_back(fif.imem_req_addr);
         exp_req_addr = exp_req_addr + 32'd4;
      end
      if (resp_v) void'(pend_q.pop_front());
      if (tb_redirect) begin
         sb_q.delete();
         exp_req_addr = tb_redirect_pc & 32'hFFFF_FFFC;
      end
      n_tests++;
      if (pend_q.size() > MAX_OUT) begin
         n_fail++;
         $display("FAIL outstanding: %0d in flight, required <= %0d", pend_q.size(), MAX_OUT);
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle();
      tb_redirect  = 1'b0;
      tb_req_ready = 1'b1;
      tb_dec_ready = 1'b1;
      sb_q.delete();
      pend_q.delete();
      exp_req_addr = RESET_PC;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      n_tests++;
      if (fif.imem_req_valid !== 1'b0 || fif.imem_req_addr !== 32'h0 || fif.dec_valid !== 1'b0 ||
          fif.dec_inst !== 32'h0 || fif.dec_pc !== 32'h0 || fif.queue_count !== 3'd0) begin
         n_fail++;
         $display("FAIL %s: req_v=%b addr=%08h dec_v=%b inst=%08h pc=%08h cnt=%0d, required all 0",
                  tag, fif.imem_req_valid, fif.imem_req_addr, fif.dec_valid,
                  fif.dec_inst, fif.dec_pc, fif.queue_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      @(negedge clock);
      check_outputs_zero("reset_outputs");
      do_reset();
   endtask

   task automatic test_basic();
      int first_fire;
      do_reset();
      lat_min = 1; lat_max = 1;
      mark();
      first_fire = cyc;
      run(12);
      n_tests++;
      if (mark_fires.size() == 0 || mark_fires[0] !== RESET_PC) begin
         n_fail++;
         $display("FAIL basic_first_addr: %0d fires, required first at %08h", mark_fires.size(), RESET_PC);
      end
      n_tests++;
      if (first_dec_cyc - first_fire !== 2 || first_dec_pc !== RESET_PC) begin
         n_fail++;
         $display("FAIL basic_latency: first pc=%08h after %0d cycles, required %08h after 2",
                  first_dec_pc, first_dec_cyc - first_fire, RESET_PC);
      end
      n_tests++;
      if (n_deliv !== 10) begin
         n_fail++;
         $display("FAIL basic_throughput: %0d delivered, required 10", n_deliv);
      end
   endtask

   task automatic test_stall();
      do_reset();
      lat_min = 1; lat_max = 1;
      tb_dec_ready = 1'b0;
      run(10);
      n_tests++;
      if (s_count !== 3'd4 || s_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_full: count=%0d req_valid=%b, required 4 0", s_count, s_req_valid);
      end
      tb_dec_ready = 1'b1;
      mark();
      run(10);
      n_tests++;
      if (n_deliv < 4 || first_dec_pc !== RESET_PC) begin
         n_fail++;
         $display("FAIL stall_drain: %0d delivered first=%08h, required >=4 first=%08h",
                  n_deliv, first_dec_pc, RESET_PC);
      end
   endtask

   task automatic test_redirect_drop();
      do_reset();
      tb_req_ready = 1'b0;
      tb_redirect = 1'b1; tb_redirect_pc = 32'h0100_0010;
      cycle();
      tb_redirect = 1'b0; tb_req_ready = 1'b1;
      lat_min = 5; lat_max = 5;
      mark();
      run(2);
      n_tests++;
      if (mark_fires.size() != 2 || pend_q.size() != 2) begin
         n_fail++;
         $display("FAIL drop_setup: %0d fires %0d pending, required 2 2", mark_fires.size(), pend_q.size());
      end
      tb_redirect = 1'b1; tb_redirect_pc = 32'h0100_0100;
      cycle();
      tb_redirect = 1'b0;
      lat_min = 1; lat_max = 1;
      mark();
      run(16);
      n_tests++;
      if (first_dec_pc !== 32'h0100_0100) begin
         n_fail++;
         $display("FAIL drop_first_pc: %08h, required 01000100", first_dec_pc);
      end
   endtask

   task automatic test_redirect_same_cycle();
      int r_cyc;
      bit found;
      do_reset();
      lat_min = 2; lat_max = 2;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (pend_q.size() == 2 && pend_q[0].due <= cyc) found = 1'b1;
         else cycle();
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL same_setup: no cycle with 2 outstanding and a response, required one within 20");
      end
      r_cyc = cyc;
      tb_redirect = 1'b1; tb_redirect_pc = 32'h0100_0300;
      mark();
      cycle();
      tb_redirect = 1'b0;
      run(12);
      n_tests++;
      if (first_dec_pc !== 32'h0100_0300 || first_dec_cyc < r_cyc + 3) begin
         n_fail++;
         $display("FAIL same_first_pc: %08h at R+%0d, required 01000300 at >= R+3",
                  first_dec_pc, first_dec_cyc - r_cyc);
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      lat_min = 1; lat_max = 1;
      run(2);
      tb_redirect = 1'b1; tb_redirect_pc = 32'h0100_0203;
      mark();
      cycle();
      tb_redirect = 1'b0;
      run(8);
      n_tests++;
      if (mark_fires.size() == 0 || mark_fires[0] !== 32'h0100_0200 || first_dec_pc !== 32'h0100_0200) begin
         n_fail++;
         $display("FAIL misaligned: %0d fires first_dec=%08h, required fetch and dec at 01000200",
                  mark_fires.size(), first_dec_pc);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      lat_min = 1; lat_max = 1;
      tb_redirect = 1'b1; tb_redirect_pc = 32'hFFFF_FFFC;
      mark();
      cycle();
      tb_redirect = 1'b0;
      run(8);
      n_tests++;
      if (mark_fires.size() < 2) begin
         n_fail++;
         $display("FAIL wrap_fires: %0d fires, required >= 2", mark_fires.size());
      end else if (mark_fires[0] !== 32'hFFFF_FFFC || mark_fires[1] !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL wrap_addr: %08h %08h, required FFFFFFFC 00000000", mark_fires[0], mark_fires[1]);
      end
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 1; lat_max = 5;
      mark();
      for (int i = 0; i < 800; i++) begin
         tb_dec_ready   = ($urandom_range(99, 0) < 70);
         tb_req_ready   = ($urandom_range(99, 0) < 80);
         tb_redirect    = ($urandom_range(99, 0) < 4);
         tb_redirect_pc = $urandom();
         cycle();
      end
      tb_redirect = 1'b0;
      n_tests++;
      if (n_deliv == 0) begin
         n_fail++;
         $display("FAIL random_progress: 0 delivered, required > 0");
      end
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("midburst_reset");
      do_reset();
      lat_min = 1; lat_max = 1;
      mark();
      run(8);
      n_tests++;
      if (first_dec_pc !== RESET_PC) begin
         n_fail++;
         $display("FAIL reset_restart: first pc=%08h, required %08h", first_dec_pc, RESET_PC);
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_basic();
      test_stall();
      test_redirect_drop();
      test_redirect_same_cycle();
      test_misaligned();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required bench completion");
      $fatal(1, "watchdog");
   end
endmodule
